uart_row_packet_ctrl: RTL and testbench
=======================================

// Module: uart_row_packet_ctrl
// PURPOSE
//  Sequences the UART-to-VGA row-upload protocol between uart_receiver, uart_transmiter and the frame buffer.
//  Parses each host packet: Y row index (2 bytes), row pixel bytes, stop byte.
//  Writes pixel bytes into the frame buffer and schedules one reply byte per received byte.
//  Aborts packets that stall. Sits in uart2vga_with_answer, between the UART pair and the frame-buffer write port.
// PARAMETERS
//  BYTE_SIZE_ROW     240      pixel bytes per row packet
//  BYTE_SIZE_Y       2        Y index bytes, big-endian (first byte = MSB)
//  HEIGHT            480      valid rows are 0..HEIGHT-1
//  STOP_BYTE         8'hDD    packet terminator
//  ANSWER_CODE       8'hAA    reply to each Y byte
//  NOT_ALL_RECEIVED  8'h11    reply on bad stop byte, bad Y, or timeout
//  TIMEOUT_CLKS      50000    max clk cycles between bytes inside a packet
//  ADDR_W            17       frame-buffer byte address width (HEIGHT*BYTE_SIZE_ROW <= 2**ADDR_W)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous reset, active low
//  rx_data    in   8       byte from uart_receiver
//  rx_done    in   1       1-clk pulse: rx_data valid
//  tx_start   out  1       1-clk start strobe to uart_transmiter
//  tx_data    out  8       reply byte; held stable from tx_start until tx_busy falls
//  tx_busy    in   1       transmitter busy
//  wr_en      out  1       frame-buffer write strobe
//  wr_addr    out  ADDR_W  Y*BYTE_SIZE_ROW + pixel index
//  wr_data    out  8       pixel byte
//  row_done   out  1       1-clk pulse: packet accepted
//  row_err    out  1       1-clk pulse: packet rejected or timed out
//  last_row   out  9       Y of the last accepted row
//  busy       out  1       high when state != IDLE
// BEHAVIOUR
//  Reset: every output is 0, FSM goes to IDLE, reply FIFO is emptied, counters are cleared.
//    A UART frame already in flight is not aborted; tx_start stays low.
//  FSM states: IDLE, GET_Y, GET_PIX, GET_STOP.
//    IDLE --rx_done--> GET_Y. The byte that triggers the transition is the Y MSB.
//    GET_Y takes BYTE_SIZE_Y bytes, then goes to GET_PIX. Each Y byte enqueues ANSWER_CODE.
//    On the last Y byte: base <= Y*BYTE_SIZE_ROW (registered multiply); y_bad <= (Y >= HEIGHT).
//    GET_PIX: a 0..BYTE_SIZE_ROW-1 index counts bytes. Each byte is echoed (enqueued unchanged).
//      wr_en pulses 1 clk after rx_done with wr_addr = base + idx, unless y_bad.
//      After the last pixel byte the FSM goes to GET_STOP.
//    GET_STOP: on rx_done, if byte == STOP_BYTE and !y_bad: enqueue STOP_BYTE, pulse row_done, update last_row.
//      Otherwise enqueue NOT_ALL_RECEIVED and pulse row_err. Either way, go to IDLE.
//  Timeout: the counter clears on every rx_done and counts only when state != IDLE.
//    At TIMEOUT_CLKS: enqueue NOT_ALL_RECEIVED, pulse row_err, go to IDLE.
//    rx_done in the same cycle as the terminal count wins: the byte is processed and no timeout fires.
//  Reply scheduling: replies go through a 4-deep reply FIFO.
//    tx_start pulses when the FIFO is non-empty, the TX FSM is idle and tx_busy==0.
//    After tx_start, tx_busy is ignored for 2 clks, then the block waits for tx_busy==0 before the next pop.
//  FIFO full on enqueue: the new reply is dropped and row_err pulses. The packet FSM itself is unaffected.
//  Latency: rx_done -> wr_en is 1 clk. rx_done -> tx_start is 2 clks when the FIFO was empty and TX is idle.
//  Widths: Y is 16 bits. base/wr_addr arithmetic is ADDR_W bits; y_bad guarantees no overflow on writes.
//  Back-to-back packets: IDLE accepts a new Y MSB in the cycle after GET_STOP exits.
// STRUCTURE
//  Package uart2vga_pkg: protocol byte constants, BYTE_SIZE_* values, HEIGHT, and the FSM state enum type.
//  Sub-module reply_fifo: synchronous FIFO, depth 4, width 8, with full/empty flags and async rst_n.
//  Top level: packet FSM, timeout counter, address generation, TX handshake FSM (T_IDLE, T_HOLD, T_WAIT).
// TESTING
//  1. Y=0x0005, 240 random bytes, 0xDD -> replies AA,AA, 240 echoes, DD.
//     wr_addr 1200..1439; row_done=1 once; last_row=5.
//  2. Y=0x01E0 (480), full packet -> wr_en never asserts; final reply 0x11; row_err pulses; last_row unchanged.
//  3. Y=0x0002, 240 bytes, stop byte 0x55 -> writes 480..719 occur; final reply 0x11; row_err pulses.
//  4. Y=0x0001 plus 10 pixel bytes, then silence -> after 50000 clks reply 0x11, row_err, busy=0.
//     Next full packet is accepted normally.
//  5. rst_n low mid-GET_PIX (byte 100) -> outputs 0, FIFO empty, IDLE.
//     The next byte is treated as a Y MSB.
//  6. Hold tx_busy=1 while 5 bytes arrive -> 4 replies queued, 5th dropped with row_err; FIFO drains in order on release.

Source files
------------

// File: rtl/uart_row_packet_ctrl_pkg.sv
// Package for the UART-to-VGA row-upload controller.
// Holds the protocol byte constants, packet geometry, frame-buffer address
// width, inter-byte timeout and the two FSM state types.
package uart_row_packet_ctrl_pkg;

   localparam int          BYTE_SIZE_ROW    = 240;
   localparam int          BYTE_SIZE_Y      = 2;
   localparam int          HEIGHT           = 480;
   localparam int          TIMEOUT_CLKS     = 50000;
   localparam int          ADDR_W           = 17;
   localparam int          TO_W             = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [7:0]  STOP_BYTE        = 8'hDD;
   localparam logic [7:0]  ANSWER_CODE      = 8'hAA;
   localparam logic [7:0]  NOT_ALL_RECEIVED = 8'h11;

   typedef enum logic [1:0] {IDLE, GET_Y, GET_PIX, GET_STOP} pkt_state_t;
   typedef enum logic [1:0] {T_IDLE, T_HOLD, T_WAIT}         tx_state_t;

endpackage

// File: rtl/uart_row_packet_ctrl_if.sv
// Bus bundle between the row-packet controller and its neighbours.
// Handshakes:
//   rx_done is a one-clock strobe qualifying rx_data; there is no back-pressure.
//   tx_start is a one-clock strobe; tx_data stays stable from tx_start until
//   the transmitter drops tx_busy.
//   wr_en is a one-clock strobe qualifying wr_addr/wr_data.
//   row_done/row_err are one-clock status pulses.
// slave  : the controller (receives rx/tx_busy, drives everything else)
// master : the surroundings (UART pair, frame buffer, status consumer)
interface uart_row_packet_ctrl_if;
   import uart_row_packet_ctrl_pkg::*;

   logic [7:0]        rx_data;
   logic              rx_done;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              row_done;
   logic              row_err;
   logic [8:0]        last_row;
   logic              busy;

   modport slave (
      input  rx_data, rx_done, tx_busy,
      output tx_start, tx_data, wr_en, wr_addr, wr_data,
             row_done, row_err, last_row, busy
   );

   modport master (
      output rx_data, rx_done, tx_busy,
      input  tx_start, tx_data, wr_en, wr_addr, wr_data,
             row_done, row_err, last_row, busy
   );

endinterface

// File: rtl/uart_row_packet_ctrl_reply_fifo.sv
// 4-deep, 8-bit synchronous reply FIFO with show-ahead read data.
// Ports: clk, rst_n (async, active low; empties the FIFO), push/wdata,
// pop, rdata (head entry), full, empty.
// A push while full and a pop while empty are ignored.
module uart_row_packet_ctrl_reply_fifo (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   logic [7:0] mem [4];
   logic [1:0] wr_ptr_q;
   logic [1:0] rd_ptr_q;
   logic [2:0] count_q;
   logic       do_push;
   logic       do_pop;

   assign full    = (count_q == 3'd4);
   assign empty   = (count_q == 3'd0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: it is only read when count_q says it is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_row_packet_ctrl.sv
// Row-upload packet controller between the UART pair and the frame buffer.
// Packet: Y (2 bytes, MSB first), BYTE_SIZE_ROW pixel bytes, STOP_BYTE.
// Every received byte schedules exactly one reply byte via the reply FIFO.
// Ports: clk, rst_n (async, active low); bus (see uart_row_packet_ctrl_if);
// dbg_pkt_state / dbg_tx_state expose the packet and TX FSM states.
module uart_row_packet_ctrl
   import uart_row_packet_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   uart_row_packet_ctrl_if.slave  bus,
   output pkt_state_t             dbg_pkt_state,
   output tx_state_t              dbg_tx_state
);

   pkt_state_t        state_q, state_d;
   tx_state_t         tx_state_q, tx_state_d;

   logic [7:0]        y_msb_q;
   logic [8:0]        y_row_q;
   logic [15:0]       y_full;
   logic [ADDR_W-1:0] base_q;
   logic              y_bad_q;
   logic [7:0]        pix_idx_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic              timeout;

   logic              push, pkt_done, pkt_err, pix_wr, last_y;
   logic [7:0]        push_data;
   logic              fifo_full, fifo_empty, pop;
   logic [7:0]        fifo_rdata;
   logic              tx_start_d, hold_q;

   logic              tx_start_q, wr_en_q, row_done_q, row_err_q;
   logic [7:0]        tx_data_q, wr_data_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [8:0]        last_row_q;

   // Only the second Y byte ever completes Y: the byte that leaves IDLE is the MSB.
   assign y_full  = {y_msb_q, bus.rx_data};
   // A byte arriving on the terminal count takes precedence over the timeout.
   assign timeout = (state_q != IDLE) && !bus.rx_done &&
                    (to_cnt_q == TO_W'(TIMEOUT_CLKS));

   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      push_data = '0;
      pkt_done  = 1'b0;
      pkt_err   = 1'b0;
      pix_wr    = 1'b0;
      last_y    = 1'b0;
      if (bus.rx_done) begin
         push = 1'b1;
         case (state_q)
            IDLE: begin
               push_data = ANSWER_CODE;
               state_d   = GET_Y;
            end
            GET_Y: begin
               push_data = ANSWER_CODE;
               last_y    = 1'b1;
               state_d   = GET_PIX;
            end
            GET_PIX: begin
               push_data = bus.rx_data;
               pix_wr    = !y_bad_q;
               if (pix_idx_q == 8'(BYTE_SIZE_ROW - 1)) state_d = GET_STOP;
            end
            GET_STOP: begin
               pkt_done  = (bus.rx_data == STOP_BYTE) && !y_bad_q;
               pkt_err   = !pkt_done;
               push_data = pkt_done ? STOP_BYTE : NOT_ALL_RECEIVED;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (timeout) begin
         push      = 1'b1;
         push_data = NOT_ALL_RECEIVED;
         pkt_err   = 1'b1;
         state_d   = IDLE;
      end
   end

   // TX handshake: pop one reply, ignore tx_busy for two clocks while the
   // transmitter picks up the strobe, then wait for it to finish.
   always_comb begin
      tx_state_d = tx_state_q;
      pop        = 1'b0;
      tx_start_d = 1'b0;
      case (tx_state_q)
         T_IDLE: if (!fifo_empty && !bus.tx_busy) begin
            pop        = 1'b1;
            tx_start_d = 1'b1;
            tx_state_d = T_HOLD;
         end
         T_HOLD:  if (hold_q) tx_state_d = T_WAIT;
         T_WAIT:  if (!bus.tx_busy) tx_state_d = T_IDLE;
         default: tx_state_d = T_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_state_q <= T_IDLE;
         y_msb_q    <= '0;
         y_row_q    <= '0;
         base_q     <= '0;
         y_bad_q    <= 1'b0;
         pix_idx_q  <= '0;
         to_cnt_q   <= '0;
         hold_q     <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         row_done_q <= 1'b0;
         row_err_q  <= 1'b0;
         last_row_q <= '0;
      end else begin
         state_q    <= state_d;
         tx_state_q <= tx_state_d;
         if (bus.rx_done && state_q == IDLE) y_msb_q <= bus.rx_data;
         if (last_y) begin
            base_q    <= ADDR_W'(32'(y_full) * 32'(BYTE_SIZE_ROW));
            y_bad_q   <= (y_full >= 16'(HEIGHT));
            y_row_q   <= y_full[8:0];
            pix_idx_q <= '0;
         end
         if (bus.rx_done && state_q == GET_PIX) pix_idx_q <= pix_idx_q + 8'd1;
         if (bus.rx_done || state_q == IDLE)             to_cnt_q <= '0;
         else if (to_cnt_q != TO_W'(TIMEOUT_CLKS))       to_cnt_q <= to_cnt_q + 1'b1;
         wr_en_q <= pix_wr;
         if (pix_wr) begin
            wr_addr_q <= base_q + ADDR_W'(pix_idx_q);
            wr_data_q <= bus.rx_data;
         end
         row_done_q <= pkt_done;
         if (pkt_done) last_row_q <= y_row_q;
         // A reply dropped on a full FIFO is reported but does not disturb the packet.
         row_err_q  <= pkt_err || (push && fifo_full);
         hold_q     <= (tx_state_q == T_HOLD) && !hold_q;
         tx_start_q <= tx_start_d;
         if (pop) tx_data_q <= fifo_rdata;
      end
   end

   uart_row_packet_ctrl_reply_fifo u_reply_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (push_data),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.tx_start   = tx_start_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.row_done   = row_done_q;
   assign bus.row_err    = row_err_q;
   assign bus.last_row   = last_row_q;
   assign bus.busy       = (state_q != IDLE);
   assign dbg_pkt_state  = state_q;
   assign dbg_tx_state   = tx_state_q;

endmodule

// File: tb/tb_uart_row_packet_ctrl.sv
// Bench for uart_row_packet_ctrl: directed packet sequence with random pixel
// data, checked against a packet-level reference of replies, writes and status.
module tb_uart_row_packet_ctrl;
   import uart_row_packet_ctrl_pkg::*;

   localparam int GAP    = 11;
   localparam int TX_LEN = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic model_busy = 1'b0;
   logic hold_busy = 1'b0;
   pkt_state_t dbg_pkt_state;
   tx_state_t  dbg_tx_state;

   uart_row_packet_ctrl_if bus ();

   uart_row_packet_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .dbg_pkt_state (dbg_pkt_state),
      .dbg_tx_state  (dbg_tx_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // transmitter model: busy for TX_LEN clocks after each start strobe
   assign bus.tx_busy = model_busy | hold_busy;
   always begin
      @(negedge clk);
      if (bus.tx_start) begin
         model_busy = 1'b1;
         repeat (TX_LEN) @(negedge clk);
         model_busy = 1'b0;
      end
   end

   // scoreboard
   logic [7:0]        exp_q[$];
   logic [ADDR_W+7:0] wr_q[$];
   int n_checks = 0, n_errors = 0;
   int n_done = 0, n_err = 0, exp_done = 0, exp_err = 0;
   int tx_cnt = 0, err_cyc = 0, drive_cyc = 0;
   logic [8:0] exp_last = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.tx_start) begin
            tx_cnt++;
            if (exp_q.size() == 0) check("tx_spurious", 32'(bus.tx_data), 32'hFFFF_FFFF);
            else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               check("tx_data", 32'(bus.tx_data), 32'(e));
            end
         end
         if (bus.wr_en) begin
            if (wr_q.size() == 0) check("wr_spurious", 32'(bus.wr_addr), 32'hFFFF_FFFF);
            else begin
               logic [ADDR_W+7:0] w;
               w = wr_q.pop_front();
               check("wr_addr", 32'(bus.wr_addr), 32'(w[ADDR_W+7:8]));
               check("wr_data", 32'(bus.wr_data), 32'(w[7:0]));
            end
         end
         if (bus.row_done) n_done++;
         if (bus.row_err) begin
            n_err++;
            err_cyc = cyc;
         end
      end
   end

   // drivers + reference model
   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      drive_cyc = cyc;
      @(posedge clk); #1;
      bus.rx_done = 1'b0;
      repeat (GAP) @(posedge clk);
   endtask

   task automatic send_y(input logic [15:0] y);
      exp_q.push_back(ANSWER_CODE);
      send_byte(y[15:8]);
      exp_q.push_back(ANSWER_CODE);
      send_byte(y[7:0]);
   endtask

   task automatic send_pixels(input logic [15:0] y, input int first, input int count);
      for (int i = first; i < first + count; i++) begin
         logic [7:0] b;
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         if (int'(y) < HEIGHT) wr_q.push_back({ADDR_W'(int'(y) * BYTE_SIZE_ROW + i), b});
         send_byte(b);
      end
   endtask

   task automatic send_stop(input logic [15:0] y, input logic [7:0] b);
      if (b == STOP_BYTE && int'(y) < HEIGHT) begin
         exp_q.push_back(STOP_BYTE);
         exp_done++;
         exp_last = y[8:0];
      end else begin
         exp_q.push_back(NOT_ALL_RECEIVED);
         exp_err++;
      end
      send_byte(b);
   endtask

   task automatic send_packet(input logic [15:0] y, input logic [7:0] stop);
      send_y(y);
      send_pixels(y, 0, BYTE_SIZE_ROW);
      send_stop(y, stop);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 400 && (exp_q.size() != 0 || bus.tx_busy || bus.tx_start); i++)
         @(posedge clk);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check({tag, "_replies_left"}, 32'(exp_q.size()), 0);
      check({tag, "_writes_left"}, 32'(wr_q.size()), 0);
      check({tag, "_row_done"}, 32'(n_done), 32'(exp_done));
      check({tag, "_row_err"}, 32'(n_err), 32'(exp_err));
      check({tag, "_last_row"}, 32'(bus.last_row), 32'(exp_last));
      check({tag, "_busy"}, 32'(bus.busy), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_start"}, 32'(bus.tx_start), 0);
      check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
      check({tag, "_wr_en"}, 32'(bus.wr_en), 0);
      check({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
      check({tag, "_row_done"}, 32'(bus.row_done), 0);
      check({tag, "_row_err"}, 32'(bus.row_err), 0);
      check({tag, "_last_row"}, 32'(bus.last_row), 0);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_pkt_state"}, 32'(dbg_pkt_state), 32'(IDLE));
      check({tag, "_tx_state"}, 32'(dbg_tx_state), 32'(T_IDLE));
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int err0, snap, delta;
      bus.rx_data = '0;
      bus.rx_done = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // 1: valid row 5
      send_packet(16'h0005, STOP_BYTE);
      wait_drain("t1");

      // 2: Y = HEIGHT is out of range, no writes, rejected
      send_packet(16'h01E0, STOP_BYTE);
      wait_drain("t2");

      // 3: valid row, wrong stop byte
      send_packet(16'h0002, 8'h55);
      wait_drain("t3");

      // 4: stall after 10 pixels, then a full packet on the last valid row
      send_y(16'h0001);
      send_pixels(16'h0001, 0, 10);
      exp_q.push_back(NOT_ALL_RECEIVED);
      exp_err++;
      err0 = n_err;
      for (int i = 0; i < TIMEOUT_CLKS + 200 && n_err == err0; i++) @(posedge clk);
      check("t4_timeout_seen", 32'(n_err != err0), 1);
      delta = err_cyc - drive_cyc;
      check("t4_timeout_window", 32'(delta >= TIMEOUT_CLKS && delta <= TIMEOUT_CLKS + 3), 1);
      wait_drain("t4a");
      send_packet(16'h01DF, STOP_BYTE);
      wait_drain("t4b");

      // 5: reset in the middle of pixel byte 100, reply still queued
      send_y(16'h0009);
      send_pixels(16'h0009, 0, 100);
      @(posedge clk); #1;
      bus.rx_data = 8'h3C;
      bus.rx_done = 1'b1;
      @(posedge clk); #1;
      bus.rx_done = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("t5_rst");
      exp_last = '0;
      snap = tx_cnt;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("t5_fifo_emptied", 32'(tx_cnt), 32'(snap));
      check("t5_pkt_state", 32'(dbg_pkt_state), 32'(IDLE));
      send_packet(16'h0007, STOP_BYTE);
      wait_drain("t5");

      // 6: transmitter held busy while 5 bytes arrive
      hold_busy = 1'b1;
      snap = tx_cnt;
      send_y(16'h0003);
      send_pixels(16'h0003, 0, 3);
      void'(exp_q.pop_back());   // fifth reply does not fit in the 4-entry queue
      exp_err++;
      @(negedge clk);
      check("t6_held_no_tx", 32'(tx_cnt), 32'(snap));
      check("t6_drop_err", 32'(n_err), 32'(exp_err));
      check("t6_still_busy", 32'(bus.busy), 1);
      hold_busy = 1'b0;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      check("t6_drained", 32'(exp_q.size()), 0);
      check("t6_drained_count", 32'(tx_cnt - snap), 4);
      send_pixels(16'h0003, 3, BYTE_SIZE_ROW - 3);
      send_stop(16'h0003, STOP_BYTE);
      wait_drain("t6");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
